// File: rtl/i2c_bus_arbiter.sv
// Two-client arbiter for a shared byte-level I2C master.
// Whole-transaction grants, round-robin ties, post-STOP guard, watchdog.
module i2c_bus_arbiter #(
  parameter int GUARD_CYC   = 1000,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       start0,
  input  logic       stop0,
  input  logic       start1,
  input  logic       stop1,
  input  logic [7:0] wr_data0,
  input  logic [7:0] wr_data1,
  output logic [1:0] ack0,
  output logic [1:0] ack1,
  output logic       rd_tick0,
  output logic       rd_tick1,
  output logic [7:0] rd_data0,
  output logic [7:0] rd_data1,
  output logic       m_start,
  output logic       m_stop,
  output logic [7:0] m_wr_data,
  input  logic [1:0] m_ack,
  input  logic       m_rd_tick,
  input  logic [7:0] m_rd_data,
  output logic       busy,
  output logic       timeout_tick
);

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, OWN0, OWN1, ABORT, GUARD
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;

  logic progress;
  logic watched;
  logic expire;
  logic own_stop;
  logic own_req;

  assign progress = m_ack[1] | m_rd_tick;
  assign watched  = (state_q == OWN0) | (state_q == OWN1) |
                    (state_q == ABORT);
  // Fires in the last cycle of TIMEOUT_CYC progress-free cycles.
  assign expire   = watched & ~progress &
                    (wd_cnt_q == WW'(TIMEOUT_CYC - 1));
  assign own_stop = (state_q == OWN0) ? stop0 : stop1;
  assign own_req  = (state_q == OWN0) ? req0 : req1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    guard_cnt_d = guard_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    unique case (state_q)
      IDLE: begin
        guard_cnt_d = '0;
        wd_cnt_d    = '0;
        if (req0 && (!req1 || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        wd_cnt_d = progress ? '0 : wd_cnt_q + 1'b1;
        if (expire || own_stop) begin
          state_d     = GUARD;
          guard_cnt_d = '0;
          wd_cnt_d    = '0;
        end else if (!own_req) begin
          state_d  = ABORT;
          wd_cnt_d = '0;
        end
      end
      ABORT: begin
        wd_cnt_d = progress ? '0 : wd_cnt_q + 1'b1;
        if (expire || progress) begin
          state_d     = GUARD;
          guard_cnt_d = '0;
          wd_cnt_d    = '0;
        end
      end
      GUARD: begin
        if (guard_cnt_q == GW'(GUARD_CYC - 1)) begin
          state_d     = IDLE;
          guard_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      guard_cnt_q <= '0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      guard_cnt_q <= guard_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign gnt0         = (state_q == OWN0);
  assign gnt1         = (state_q == OWN1);
  assign busy         = (state_q != IDLE);
  assign timeout_tick = expire;

  always_comb begin
    m_start   = 1'b0;
    m_stop    = 1'b0;
    m_wr_data = 8'h00;
    ack0      = 2'b00;
    ack1      = 2'b00;
    rd_tick0  = 1'b0;
    rd_tick1  = 1'b0;
    rd_data0  = 8'h00;
    rd_data1  = 8'h00;
    unique case (state_q)
      OWN0: begin
        m_start   = start0;
        m_stop    = stop0;
        m_wr_data = wr_data0;
        ack0      = m_ack;
        rd_tick0  = m_rd_tick;
        rd_data0  = m_rd_data;
      end
      OWN1: begin
        m_start   = start1;
        m_stop    = stop1;
        m_wr_data = wr_data1;
        ack1      = m_ack;
        rd_tick1  = m_rd_tick;
        rd_data1  = m_rd_data;
      end
      // Hold STOP so the master closes the bus at the next byte boundary.
      ABORT: m_stop = 1'b1;
      default: ;
    endcase
  end

endmodule
